// File: rtl/alu_issue_ctrl_if.sv
// Request/response and ALU-side bus of the ALU issue controller.
// The slave modport is the controller; the master modport is the
// requester together with the ALU that serves it.
interface alu_issue_ctrl_if;
    // request channel
    logic        req_valid;
    logic        req_ready;
    logic [5:0]  req_op;
    logic [31:0] req_a;
    logic [31:0] req_b;

    // downstream ALU
    logic [31:0] alu_dataA;
    logic [31:0] alu_dataB;
    logic [5:0]  alu_Signal;
    logic [31:0] alu_Output;

    // response channel
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_lo;
    logic [31:0] rsp_hi;
    logic        rsp_err;

    // status
    logic        busy;

    modport slave (
        input  req_valid, req_op, req_a, req_b, alu_Output, rsp_ready,
        output req_ready, alu_dataA, alu_dataB, alu_Signal,
               rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
    );

    modport master (
        output req_valid, req_op, req_a, req_b, alu_Output, rsp_ready,
        input  req_ready, alu_dataA, alu_dataB, alu_Signal,
               rsp_valid, rsp_lo, rsp_hi, rsp_err, busy
    );
endinterface

// File: rtl/alu_issue_ctrl.sv
// ALU issue controller: accepts one operation at a time, sequences the
// function code onto an external ALU (including the MFHI/MFLO reads that
// follow MULTU/DIVU), and returns the result over a valid/ready response.
module alu_issue_ctrl #(
    parameter int MD_CYCLES     = 35, // cycles MULTU/DIVU code is held before HI/LO reads
    parameter int SIMPLE_CYCLES = 1   // cycles a single-result code is held; 1..MD_CYCLES
) (
    input  logic            clk,
    input  logic            reset,
    alu_issue_ctrl_if.slave bus
);

    localparam int CW = $clog2(MD_CYCLES + 1);

    localparam logic [5:0] OP_AND   = 6'd36;
    localparam logic [5:0] OP_OR    = 6'd37;
    localparam logic [5:0] OP_ADD   = 6'd32;
    localparam logic [5:0] OP_SUB   = 6'd34;
    localparam logic [5:0] OP_SLT   = 6'd42;
    localparam logic [5:0] OP_SRL   = 6'd2;
    localparam logic [5:0] OP_MULTU = 6'd25;
    localparam logic [5:0] OP_DIVU  = 6'd27;
    localparam logic [5:0] SIG_IDLE = 6'd0;
    localparam logic [5:0] SIG_MFHI = 6'd16;
    localparam logic [5:0] SIG_MFLO = 6'd18;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_EXEC,
        ST_RD_HI,
        ST_RD_LO,
        ST_RESP
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [5:0]    r_op;
    logic [31:0]   r_a;
    logic [31:0]   r_b;
    logic [31:0]   r_lo;
    logic [31:0]   r_hi;
    logic          r_err;
    logic [CW-1:0] r_cnt;

    logic          w_idle;
    logic          w_accept;
    logic          w_supported;
    logic          w_req_md;
    logic          w_op_md;
    logic          w_cnt_last;

    // Classify the incoming op code: supported at all, and two-result or not.
    always_comb begin
        w_supported = 1'b0;
        w_req_md    = 1'b0;
        case (bus.req_op)
            OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_SRL: w_supported = 1'b1;
            OP_MULTU, OP_DIVU: begin
                w_supported = 1'b1;
                w_req_md    = 1'b1;
            end
            default: ;
        endcase
    end

    // Acceptance is derived from state directly (not from req_ready) so the
    // next-state logic below has no path through its own outputs.
    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle && !reset && bus.req_valid;
    assign w_op_md    = (r_op == OP_MULTU) || (r_op == OP_DIVU);
    // Counter is loaded with the hold length and counts down; the last EXEC
    // cycle is the one where it reads 1, so it never passes through 0 in EXEC.
    assign w_cnt_last = (r_cnt == CW'(1));

    // State register.
    always_ff @(posedge clk) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    // Next state and state-decoded outputs.
    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.alu_Signal = SIG_IDLE;
        bus.rsp_valid  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                bus.req_ready = !reset;
                if (w_accept) w_next = w_supported ? ST_EXEC : ST_RESP;
            end
            ST_EXEC: begin
                bus.alu_Signal = r_op;
                if (w_cnt_last) w_next = w_op_md ? ST_RD_HI : ST_RESP;
            end
            ST_RD_HI: begin
                bus.alu_Signal = SIG_MFHI;
                w_next         = ST_RD_LO;
            end
            ST_RD_LO: begin
                bus.alu_Signal = SIG_MFLO;
                w_next         = ST_RESP;
            end
            ST_RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) w_next = ST_IDLE;
            end
            default: w_next = ST_IDLE;
        endcase
    end

    // Operand/op capture, hold counter and result capture from the ALU.
    // Operands are only updated for supported ops so a rejected request
    // leaves the ALU inputs untouched.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_op  <= SIG_IDLE;
            r_a   <= '0;
            r_b   <= '0;
            r_lo  <= '0;
            r_hi  <= '0;
            r_err <= 1'b0;
            r_cnt <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_err <= !w_supported;
                        r_lo  <= '0;
                        r_hi  <= '0;
                        if (w_supported) begin
                            r_op  <= bus.req_op;
                            r_a   <= bus.req_a;
                            r_b   <= bus.req_b;
                            r_cnt <= w_req_md ? CW'(MD_CYCLES) : CW'(SIMPLE_CYCLES);
                        end
                    end
                end
                ST_EXEC: begin
                    if (w_cnt_last) begin
                        r_cnt <= '0;
                        if (!w_op_md) r_lo <= bus.alu_Output;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                ST_RD_HI: r_hi <= bus.alu_Output;
                ST_RD_LO: r_lo <= bus.alu_Output;
                default: ;
            endcase
        end
    end

    // Registered values straight to the bus.
    assign bus.alu_dataA = r_a;
    assign bus.alu_dataB = r_b;
    assign bus.rsp_lo    = r_lo;
    assign bus.rsp_hi    = r_hi;
    assign bus.rsp_err   = r_err;
    assign bus.busy      = !w_idle;

endmodule
